// File: rtl/accelerator_pkg.sv
// Shared constants for the LRAHash accelerator configuration/readback block.
// Holds the AddrBus/DataBus widths, the configuration memory depth and the
// word returned for out-of-range reads when ACCEL_ADDR_CHECK_EN is defined.
package accelerator_pkg;

    localparam int ACCEL_ADDR_WIDTH = 16;
    localparam int ACCEL_DATA_WIDTH = 32;
    localparam int ACCEL_CFG_DEPTH  = 256;

    localparam int ACCEL_RESP_FIFO_DEPTH = 2;

    localparam logic [31:0] ACCEL_OOR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/accel_resp_fifo.sv
// Two-entry valid/ready response buffer for the configuration read path.
// in_rdy also goes high when the buffer is full but the head is being popped
// in the same cycle, so back-to-back reads keep full throughput.
module accel_resp_fifo
    import accelerator_pkg::*;
#(
    parameter int DATA_WIDTH = ACCEL_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  in_rdy,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0] slot [ACCEL_RESP_FIFO_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  do_push;
    logic                  do_pop;

    assign out_vld  = (count != 2'd0);
    assign do_pop   = out_vld & out_rdy;
    assign in_rdy   = (count != 2'd2) | do_pop;
    assign do_push  = push & in_rdy;
    assign out_data = slot[rd_ptr];

    // Slot storage, ring pointers and occupancy; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot[0] <= '0;
            slot[1] <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
        end else begin
            if (do_push) begin
                slot[wr_ptr] <= push_data;
                wr_ptr       <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/accelerator.sv
// Host-facing configuration memory with a single-cycle write port and a
// buffered request/response read port feeding the hashing datapath.
// Optional feature macro: ACCEL_ADDR_CHECK_EN -- when defined, addresses at or
// above CFG_DEPTH are out of range (writes dropped, reads return DEAD_BEEF);
// otherwise the upper address bits are ignored and addresses alias.
module accelerator
    import accelerator_pkg::*;
#(
    parameter int ADDR_WIDTH = ACCEL_ADDR_WIDTH,
    parameter int DATA_WIDTH = ACCEL_DATA_WIDTH,
    parameter int CFG_DEPTH  = ACCEL_CFG_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_en,
    output logic                  write_rdy,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_en,
    output logic                  read_rdy,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    input  logic                  read_data_rdy,
    output logic                  read_data_vld,
    output logic [DATA_WIDTH-1:0] read_data
);

    localparam int IDX_WIDTH = (CFG_DEPTH > 1) ? $clog2(CFG_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] cfg_mem [CFG_DEPTH];
    logic [IDX_WIDTH-1:0]  write_idx;
    logic [IDX_WIDTH-1:0]  read_idx;
    logic                  write_fire;
    logic                  write_hit;
    logic                  read_fire;
    logic [DATA_WIDTH-1:0] read_word;
    logic                  fifo_in_rdy;

    assign write_rdy  = ~rst;
    assign write_fire = write_en & write_rdy;
    assign read_rdy   = fifo_in_rdy;
    assign read_fire  = read_en & read_rdy & ~rst;
    assign write_idx  = write_addr[IDX_WIDTH-1:0];
    assign read_idx   = read_addr[IDX_WIDTH-1:0];

`ifdef ACCEL_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(CFG_DEPTH);
    localparam logic [DATA_WIDTH-1:0] OOR_DATA  = DATA_WIDTH'(ACCEL_OOR_WORD);

    logic write_in_range;
    logic read_in_range;

    assign write_in_range = ({1'b0, write_addr} < DEPTH_EXT);
    assign read_in_range  = ({1'b0, read_addr} < DEPTH_EXT);
    assign write_hit      = write_fire & write_in_range;
    assign read_word      = read_in_range ? cfg_mem[read_idx] : OOR_DATA;
`else
    logic unused_addr_bits;

    assign unused_addr_bits = ^{write_addr, read_addr};
    assign write_hit        = write_fire;
    assign read_word        = cfg_mem[read_idx];
`endif

    // Configuration word storage; the read path samples the pre-write value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CFG_DEPTH; i++) begin
                cfg_mem[i] <= '0;
            end
        end else if (write_hit) begin
            cfg_mem[write_idx] <= write_data;
        end
    end

    accel_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (read_fire),
        .push_data (read_word),
        .in_rdy    (fifo_in_rdy),
        .out_vld   (read_data_vld),
        .out_rdy   (read_data_rdy),
        .out_data  (read_data)
    );

endmodule

// File: tb/tb_accelerator.sv
// Self-checking bench for accelerator: a queue-based behavioural model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
// Honours ACCEL_ADDR_CHECK_EN the same way as the design.
module tb_accelerator;

    logic        clk;
    logic        rst;
    logic        write_en;
    logic        write_rdy;
    logic [15:0] write_addr;
    logic [31:0] write_data;
    logic        read_en;
    logic        read_rdy;
    logic [15:0] read_addr;
    logic        read_data_rdy;
    logic        read_data_vld;
    logic [31:0] read_data;

    int num_checks = 0;
    int num_fails  = 0;

    logic [31:0] model_mem [256];
    logic [31:0] model_q [$];

`ifdef ACCEL_ADDR_CHECK_EN
    localparam logic [31:0] EXP_HI_READ = 32'hDEAD_BEEF;
    localparam logic [31:0] EXP_LO_READ = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_HI_READ = 32'hCAFE_0000;
    localparam logic [31:0] EXP_LO_READ = 32'hCAFE_0000;
`endif

    accelerator dut (
        .clk           (clk),
        .rst           (rst),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .read_en       (read_en),
        .read_rdy      (read_rdy),
        .read_addr     (read_addr),
        .read_data_rdy (read_data_rdy),
        .read_data_vld (read_data_vld),
        .read_data     (read_data)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point used by the model checker and the literal checks
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        num_checks++;
        if (actual !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [15:0] a);
`ifdef ACCEL_ADDR_CHECK_EN
        if (a >= 16'd256) return 32'hDEAD_BEEF;
`endif
        return model_mem[a % 16'd256];
    endfunction

    function automatic void model_write(input logic [15:0] a, input logic [31:0] d);
`ifdef ACCEL_ADDR_CHECK_EN
        if (a >= 16'd256) return;
`endif
        model_mem[a % 16'd256] = d;
    endfunction

    // Behavioural model: memory array plus an ordered queue of pending responses
    always @(posedge clk) begin
        bit          pop_now;
        bit          rd_ok;
        logic [31:0] rd_word;
        if (rst) begin
            foreach (model_mem[i]) model_mem[i] = '0;
            model_q.delete();
        end else begin
            pop_now = (model_q.size() != 0) && read_data_rdy;
            rd_ok   = read_en && ((model_q.size() < 2) || pop_now);
            rd_word = model_read(read_addr);
            if (pop_now) void'(model_q.pop_front());
            if (rd_ok) model_q.push_back(rd_word);
            if (write_en) model_write(write_addr, write_data);
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        checkOutput("write_rdy", 32'(write_rdy), 32'(!rst));
        checkOutput("read_data_vld", 32'(read_data_vld), 32'(model_q.size() != 0));
        checkOutput("read_rdy", 32'(read_rdy),
                    32'((model_q.size() < 2) || ((model_q.size() != 0) && read_data_rdy)));
        if (model_q.size() != 0) begin
            checkOutput("read_data", read_data, model_q[0]);
        end
    end

    // Drive one cycle of inputs, then advance past the next rising edge
    task automatic applyStimulus(input logic we, input logic [15:0] wa, input logic [31:0] wd,
                                 input logic re, input logic [15:0] ra, input logic drdy);
        write_en      = we;
        write_addr    = wa;
        write_data    = wd;
        read_en       = re;
        read_addr     = ra;
        read_data_rdy = drdy;
        @(negedge clk);
        #1;
    endtask

    // Watchdog so the run always ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with literal expectations
    initial begin
        rst = 1'b1;
        write_en = 1'b0; write_addr = '0; write_data = '0;
        read_en = 1'b0; read_addr = '0; read_data_rdy = 1'b0;
        @(negedge clk);
        #1;

        applyStimulus(0, 16'h0, 32'h0, 0, 16'h0, 0);
        applyStimulus(0, 16'h0, 32'h0, 0, 16'h0, 0);
        checkOutput("reset write_rdy", 32'(write_rdy), 32'd0);
        checkOutput("reset read_data_vld", 32'(read_data_vld), 32'd0);
        checkOutput("reset read_rdy", 32'(read_rdy), 32'd1);
        rst = 1'b0;

        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0005, 1);
        checkOutput("post-reset write_rdy", 32'(write_rdy), 32'd1);
        checkOutput("read5 vld", 32'(read_data_vld), 32'd1);
        checkOutput("read5 data", read_data, 32'h0);

        applyStimulus(1, 16'h0003, 32'h1234_5678, 0, 16'h0, 1);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0003, 1);
        checkOutput("read3 data", read_data, 32'h1234_5678);

        applyStimulus(1, 16'h0010, 32'hAAAA_0001, 1, 16'h0010, 1);
        checkOutput("rbw old data", read_data, 32'h0);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0010, 1);
        checkOutput("rbw new data", read_data, 32'hAAAA_0001);

        applyStimulus(1, 16'h0001, 32'h11, 0, 16'h0, 1);
        applyStimulus(1, 16'h0002, 32'h22, 0, 16'h0, 1);
        applyStimulus(1, 16'h0003, 32'h33, 0, 16'h0, 1);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0001, 0);
        checkOutput("bp first data", read_data, 32'h11);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0002, 0);
        checkOutput("bp full read_rdy", 32'(read_rdy), 32'd0);
        checkOutput("bp full data", read_data, 32'h11);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0003, 0);
        checkOutput("bp stall read_rdy", 32'(read_rdy), 32'd0);
        checkOutput("bp stall data", read_data, 32'h11);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0003, 1);
        checkOutput("drain second", read_data, 32'h22);
        applyStimulus(0, 16'h0, 32'h0, 0, 16'h0, 1);
        checkOutput("drain third", read_data, 32'h33);
        applyStimulus(0, 16'h0, 32'h0, 0, 16'h0, 1);
        checkOutput("drained vld", 32'(read_data_vld), 32'd0);

        applyStimulus(1, 16'h0100, 32'hCAFE_0000, 0, 16'h0, 1);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0100, 1);
        checkOutput("range high read", read_data, EXP_HI_READ);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0000, 1);
        checkOutput("range low read", read_data, EXP_LO_READ);

        applyStimulus(1, 16'h00FF, 32'h5A5A_A5A5, 0, 16'h0, 1);
        applyStimulus(1, 16'hFFFF, 32'h0F0F_0F0F, 1, 16'h00FF, 1);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'hFFFF, 1);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h00FF, 1);
        applyStimulus(0, 16'h0, 32'h0, 0, 16'h0, 1);

        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0003, 0);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0010, 0);
        checkOutput("buffered vld", 32'(read_data_vld), 32'd1);
        checkOutput("buffered data", read_data, 32'h33);
        rst = 1'b1;
        applyStimulus(0, 16'h0, 32'h0, 0, 16'h0, 0);
        checkOutput("mid-reset vld", 32'(read_data_vld), 32'd0);
        rst = 1'b0;
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0003, 1);
        checkOutput("cleared word 3", read_data, 32'h0);
        applyStimulus(0, 16'h0, 32'h0, 1, 16'h0010, 1);
        checkOutput("cleared word 0x10", read_data, 32'h0);
        applyStimulus(0, 16'h0, 32'h0, 0, 16'h0, 1);
        applyStimulus(0, 16'h0, 32'h0, 0, 16'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
